fpu_float_sqrt_seq: RTL and testbench
=====================================

// Module: fpu_float_sqrt_seq
// PURPOSE
// - Sequential single-precision square root, one result bit per cycle (restoring digit recurrence).
// - Produces an unrounded float plus 3 guard bits {guard, round, sticky}.
// - Feeds the float rounding stage directly downstream; round mode passes through unchanged.
// PARAMETERS
// - none; format fixed to fpu_float_fields_t (1/8/23). Mantissa iterations fixed at 26 (24 result + 2 guard).
// PORTS
// - clk          in   1   clock; all state on rising edge
// - rst          in   1   asynchronous, active-high reset
// - in_valid     in   1   operand valid
// - in_ready     out  1   unit can accept an operand
// - in_number    in   32  fpu_float_fields_t operand
// - in_round     in   3   fpu_round_mode_t, carried to output
// - out_valid    out  1   result valid
// - out_ready    in   1   consumer accepts result
// - out_number   out  32  fpu_float_fields_t unrounded result
// - out_guard    out  3   fpu_guard_bits_t {g, r, sticky}
// - out_round    out  3   registered copy of in_round
// BEHAVIOUR
// - Reset values: state IDLE, in_ready=1, out_valid=0, out_number=0, out_guard=0, out_round=0.
// - FSM IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: in_ready=1; in_valid&in_ready latches operand and goes to CALC, or to DONE on early-out.
//   - CALC: 26 cycles, counter 25..0; each cycle shifts 2 radicand bits into the remainder.
//     Trial-subtracts {root,01}; shifts root bit in (1 if no borrow).
//   - DONE: out_valid=1; outputs held stable until out_ready; out_valid&out_ready -> IDLE.
//     in_ready=0 in CALC/DONE; no operand accepted in the same cycle the result leaves.
// - Latency: out_valid rises 27 cycles after the input handshake cycle for normal operands.
// - Radicand: {1,mantissa}; left-shifted 1 extra when exponent[0]==0 (odd unbiased exponent).
// - Result exponent = ((exponent - !exponent[0]) >> 1) + 64, 8-bit unsigned; cannot overflow or underflow.
// - Result: root bit 23 is the implicit 1 (always set); root[22:0] is the mantissa; root bits -1, -2 are g, r.
//   sticky = (final remainder != 0).
// - Specials, guard=000:
//   - +0 -> +0; -0 -> -0; +inf -> +inf.
//   - NaN or any negative nonzero (incl. -inf) -> FPU_FLOAT_NAN.
//   - Denormal (exponent 0, mantissa != 0) -> +0, flush.
// - Reset mid-operation: async clear to reset values; the in-flight operand is dropped, no output.
// - out_round always equals the in_round captured at the handshake.
// CONFIGURATION
// - FPU_SQRT_EARLY_OUT_EN defined:
//   - Specials go IDLE -> DONE directly; out_valid rises 1 cycle after the handshake.
// - FPU_SQRT_EARLY_OUT_EN undefined:
//   - Specials still run the 26 CALC cycles (fixed 27-cycle latency).
//   - The iteration result is discarded and the special result is substituted.
// TESTING
// - 0x40800000 (4.0), out_ready=1 -> out_number 0x40000000, out_guard 000, out_valid exactly 27 cycles after handshake.
// - 0x40000000 (2.0) -> out_number 0x3FB504F3, out_guard 001.
// - 0x3E800000 (0.25) -> 0x3F000000, guard 000.
// - Specials: 0xBF800000 -> FPU_FLOAT_NAN; 0x80000000 -> 0x80000000; 0x7F800000 -> 0x7F800000; 0x00000001 -> 0x00000000.
//   Latency 1 with FPU_SQRT_EARLY_OUT_EN, 27 without.
// - Backpressure: 9.0, out_ready=0 for 10 cycles after out_valid -> out_number 0x40400000 stable, in_ready=0 throughout;
//   out_ready=1 -> next cycle in_ready=1.
// - Reset in CALC cycle 10 -> out_valid=0, in_ready=1 immediately. Then 16.0 -> 0x40800000 after 27 cycles.

Source files
------------

// File: rtl/fpu_float_sqrt_seq.sv
// fpu_float_sqrt_seq -- sequential single-precision square root.
//
// Restoring digit recurrence, one root bit per clock. 26 iterations produce
// 24 result bits (implicit 1 + 23 mantissa bits) and 2 guard bits. The result
// is left unrounded. It carries {guard, round, sticky} for the rounding stage
// downstream. The round mode is passed through unchanged.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      operand valid           in_ready   unit idle, can accept
//   in_number     operand (1/8/23)        in_round   round mode, carried along
//   out_valid     result valid            out_ready  consumer accepts result
//   out_number    unrounded result        out_guard  {g, r, sticky}
//   out_round     round mode captured at the input handshake
//
// Build option:
//   FPU_SQRT_EARLY_OUT_EN  special operands (zero, inf, NaN, negative,
//                          denormal) skip the recurrence. The result is then
//                          valid 1 cycle after the handshake instead of 27.

package fpu_float_pkg;
   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } fpu_float_fields_t;

   typedef logic [2:0] fpu_round_mode_t;

   typedef struct packed {
      logic g;
      logic r;
      logic sticky;
   } fpu_guard_bits_t;

   localparam fpu_float_fields_t FPU_FLOAT_NAN = fpu_float_fields_t'(32'h7FC0_0000);
endpackage

module fpu_float_sqrt_seq
   import fpu_float_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  fpu_float_fields_t in_number,
   input  fpu_round_mode_t   in_round,
   output logic              out_valid,
   input  logic              out_ready,
   output fpu_float_fields_t out_number,
   output fpu_guard_bits_t   out_guard,
   output fpu_round_mode_t   out_round
);

`ifdef FPU_SQRT_EARLY_OUT_EN
   localparam logic EARLY_OUT = 1'b1;
`else
   localparam logic EARLY_OUT = 1'b0;
`endif

   localparam logic [4:0] LAST_ITER = 5'd25;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            state_q, state_nxt;

   logic [51:0]       rad_q;         // radicand, consumed 2 bits per cycle from the top
   logic [29:0]       rem_q;         // partial remainder (< 2*root + 1, so 28 bits suffice; 2 spare)
   logic [25:0]       root_q;        // root bits built so far
   logic [4:0]        cnt_q;
   logic [7:0]        res_exp_q;
   logic              special_q;
   fpu_float_fields_t special_val_q;

   // ---------------- operand decode ----------------
   logic              in_special;
   fpu_float_fields_t in_special_val;
   logic [51:0]       rad_init;
   logic [7:0]        exp_adj;
   logic [7:0]        res_exp;

   always_comb begin
      in_special     = 1'b0;
      in_special_val = '0;
      if (in_number.exponent == 8'hFF) begin
         in_special     = 1'b1;
         in_special_val = (in_number.mantissa != '0 || in_number.sign) ? FPU_FLOAT_NAN : in_number;
      end else if (in_number.exponent == 8'h00) begin
         // Signed zero keeps its sign. A denormal of either sign flushes to +0.
         in_special     = 1'b1;
         in_special_val = (in_number.mantissa == '0) ? in_number : '0;
      end else if (in_number.sign) begin
         in_special     = 1'b1;
         in_special_val = FPU_FLOAT_NAN;
      end
   end

   // An even biased exponent is an odd unbiased one. In that case one factor
   // of 2 moves into the radicand, so the exponent halves cleanly. The radicand
   // is aligned so the 26-bit integer root has its MSB at the implicit 1.
   assign rad_init = in_number.exponent[0] ? {2'b01, in_number.mantissa, 27'd0}
                                           : {1'b1,  in_number.mantissa, 28'd0};
   assign exp_adj  = in_number.exponent - {7'd0, ~in_number.exponent[0]};
   assign res_exp  = {1'b0, exp_adj[7:1]} + 8'd64;

   // ---------------- one recurrence step ----------------
   logic [29:0] rem_shift;
   logic [30:0] diff;
   logic        borrow;
   logic [29:0] rem_nxt;
   logic [25:0] root_nxt;

   assign rem_shift = {rem_q[27:0], rad_q[51:50]};
   assign diff      = {1'b0, rem_shift} - {3'd0, root_q, 2'b01};
   assign borrow    = diff[30];
   assign rem_nxt   = borrow ? rem_shift : diff[29:0];
   assign root_nxt  = {root_q[24:0], ~borrow};

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = (EARLY_OUT && in_special) ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (cnt_q == 5'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rad_q         <= '0;
         rem_q         <= '0;
         root_q        <= '0;
         cnt_q         <= '0;
         res_exp_q     <= '0;
         special_q     <= 1'b0;
         special_val_q <= '0;
         out_number    <= '0;
         out_guard     <= '0;
         out_round     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  rad_q         <= rad_init;
                  rem_q         <= '0;
                  root_q        <= '0;
                  cnt_q         <= LAST_ITER;
                  res_exp_q     <= res_exp;
                  special_q     <= in_special;
                  special_val_q <= in_special_val;
                  out_round     <= in_round;
                  if (EARLY_OUT && in_special) begin
                     out_number <= in_special_val;
                     out_guard  <= '0;
                  end
               end
            end
            S_CALC: begin
               rad_q  <= {rad_q[49:0], 2'b00};
               rem_q  <= rem_nxt;
               root_q <= root_nxt;
               cnt_q  <= cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  // Specials also run the full recurrence when the early-out is
                  // not built in. The root computed for them is discarded here.
                  if (special_q) begin
                     out_number <= special_val_q;
                     out_guard  <= '0;
                  end else begin
                     out_number <= {1'b0, res_exp_q, root_nxt[24:2]};
                     out_guard  <= {root_nxt[1:0], (rem_nxt != '0)};
                  end
               end
            end
            default: ;  // S_DONE: outputs hold until accepted
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_float_sqrt_seq.sv
module tb_fpu_float_sqrt_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_number;
   logic [2:0]  in_round;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_number;
   logic [2:0]  out_guard;
   logic [2:0]  out_round;

   int tests_run    = 0;
   int tests_failed = 0;

`ifdef FPU_SQRT_EARLY_OUT_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 27;
`endif

   typedef struct {
      logic [31:0] num;
      logic [2:0]  guard;
      logic [2:0]  rnd;
      int          lat;
   } exp_t;

   exp_t sb[$];

   fpu_float_sqrt_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_number  (in_number),
      .in_round   (in_round),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_number (out_number),
      .out_guard  (out_guard),
      .out_round  (out_round)
   );

   always #5 clk = ~clk;

   // Reference: exact integer square root via real sqrt plus correction.
   function automatic exp_t model(input logic [31:0] a, input logic [2:0] rm);
      exp_t        e;
      logic [63:0] x, r;
      int          ue;
      real         rv;
      e.rnd   = rm;
      e.guard = 3'b000;
      e.lat   = SPEC_LAT;
      if (a[30:23] == 8'hFF) begin
         e.num = (a[22:0] != 0 || a[31]) ? 32'h7FC0_0000 : a;
      end else if (a[30:23] == 8'h00) begin
         e.num = (a[22:0] == 0) ? a : 32'h0;
      end else if (a[31]) begin
         e.num = 32'h7FC0_0000;
      end else begin
         ue = int'(a[30:23]) - 127;
         x  = {40'd0, 1'b1, a[22:0]} << (ue[0] ? 28 : 27);
         rv = $sqrt(real'(x));
         r  = 64'(longint'(rv));
         while (r * r > x) r = r - 1;
         while ((r + 1) * (r + 1) <= x) r = r + 1;
         e.num   = {1'b0, 8'((ue >>> 1) + 127), r[24:2]};
         e.guard = {r[1:0], (x - r * r) != 0};
         e.lat   = 27;
      end
      return e;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [2:0] rm, input int stall, input string nm);
      exp_t        e;
      int          lat, n, bad;
      logic [31:0] held;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s ready_wait: in_ready=%b required 1", nm, in_ready);
      end
      in_number = a; in_round = rm; in_valid = 1'b1; out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_number = $urandom;
      in_round  = 3'($urandom);
      sb.push_back(model(a, rm));
      lat = 1; bad = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) bad++;
         @(posedge clk); #1; lat++;
      end
      if (in_ready !== 1'b0) bad++;
      e = sb.pop_front();
      tests_run++;
      if (lat != e.lat) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d required %0d", nm, lat, e.lat);
      end
      tests_run++;
      if (out_number !== e.num) begin
         tests_failed++;
         $display("FAIL %s number: got %h required %h", nm, out_number, e.num);
      end
      tests_run++;
      if (out_guard !== e.guard) begin
         tests_failed++;
         $display("FAIL %s guard: got %b required %b", nm, out_guard, e.guard);
      end
      tests_run++;
      if (out_round !== e.rnd) begin
         tests_failed++;
         $display("FAIL %s round: got %b required %b", nm, out_round, e.rnd);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL %s busy_ready: in_ready high in %0d busy cycles, required 0", nm, bad);
      end
      held = out_number;
      bad  = 0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_number !== held || in_ready !== 1'b0) bad++;
      end
      if (stall > 0) begin
         tests_run++;
         if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s stall_hold: %0d unstable cycles, required 0", nm, bad);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_number !== 32'h0 ||
          out_guard !== 3'b000 || out_round !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_state: rdy=%b vld=%b num=%h g=%b rnd=%b required 1 0 0 0 0",
                  in_ready, out_valid, out_number, out_guard, out_round);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      run_op(32'h4080_0000, 3'd1, 0, "sqrt4");
      run_op(32'h4000_0000, 3'd2, 0, "sqrt2");
      run_op(32'h3E80_0000, 3'd3, 0, "sqrt0p25");
      run_op(32'h0080_0000, 3'd4, 0, "min_normal");
      run_op(32'h7F7F_FFFF, 3'd0, 0, "max_normal");
   endtask

   task automatic test_specials();
      run_op(32'hBF80_0000, 3'd1, 0, "neg_one");
      run_op(32'h8000_0000, 3'd2, 0, "neg_zero");
      run_op(32'h0000_0000, 3'd3, 0, "pos_zero");
      run_op(32'h7F80_0000, 3'd4, 0, "pos_inf");
      run_op(32'hFF80_0000, 3'd5, 0, "neg_inf");
      run_op(32'h7FC0_1234, 3'd6, 0, "nan_in");
      run_op(32'h0000_0001, 3'd7, 0, "denormal");
   endtask

   task automatic test_backpressure();
      run_op(32'h4110_0000, 3'd5, 10, "bp_sqrt9");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         run_op({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 3'($urandom), i % 3, "rand");
   endtask

   task automatic test_reset_mid();
      in_number = 32'h4110_0000; in_round = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_number !== 32'h0) begin
         tests_failed++;
         $display("FAIL mid_reset: vld=%b rdy=%b num=%h required 0 1 0", out_valid, in_ready, out_number);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_op(32'h4180_0000, 3'd2, 0, "after_reset_sqrt16");
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_number = '0; in_round = '0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_specials();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
